// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and FSM encoding for the pipe_hold register bank
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          FUNC_W    = 15;
    localparam int          REG_W     = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        BSTALL = 2'd2
    } state_t;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear and increment enable
module sat_cnt #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   MAX_VAL = '1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != MAX_VAL)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_hold.sv
// rtl/pipe_hold.sv - IF/ID and ID/EX register bank enforcing hazard stalls
// Optional stall performance counters are built when PIPE_HOLD_PERF_EN is defined.
module pipe_hold
    import pipe_pkg::*;
#(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IFstall,
    input  logic              IDstall,
    input  logic [31:0]       IFinstr,
    input  logic [31:0]       IFpc,
    input  logic [FUNC_W-1:0] IDfunc,
    input  logic              IDRegWr,
    input  logic [REG_W-1:0]  IDrw,
    output logic              PCwrite,
    output logic [31:0]       IDinstr,
    output logic [31:0]       IDpc,
    output logic [FUNC_W-1:0] EXfunc,
    output logic              EXRegWr,
    output logic [REG_W-1:0]  EXrw,
`ifdef PIPE_HOLD_PERF_EN
    output logic [CNT_W-1:0]  data_stalls,
    output logic [CNT_W-1:0]  branch_stalls,
`endif
    output logic              stall_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);

    logic              w_ds;
    logic              w_bs;
    logic              w_stall;
    logic              w_err_set;
    logic [RUN_W-1:0]  w_run_cnt;
    state_t            r_state;
    state_t            w_next;

    logic [31:0]       r_id_instr;
    logic [31:0]       r_id_pc;
    logic [FUNC_W-1:0] r_ex_func;
    logic              r_ex_regwr;
    logic [REG_W-1:0]  r_ex_rw;
    logic              r_err;

    // A data stall outranks a branch stall when both are raised.
    assign w_ds    = IDstall;
    assign w_bs    = IFstall & ~IDstall;
    assign w_stall = w_ds | w_bs;
    assign PCwrite = ~rst & ~IFstall & ~IDstall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = RUN;
        if (w_ds) begin
            w_next = DSTALL;
        end else if (w_bs) begin
            w_next = BSTALL;
        end
    end

    sat_cnt #(
        .W       (RUN_W),
        .MAX_VAL (RUN_W'(MAX_STALL + 1))
    ) u_run_cnt (
        .clk (clk),
        .clr (rst | ~w_stall),
        .inc (w_stall),
        .q   (w_run_cnt)
    );

    // Any run already counted means the previous cycle stalled, so r_state is not RUN.
    assign w_err_set = w_stall && (w_run_cnt >= RUN_W'(MAX_STALL))
                       && ((MAX_STALL == 0) || (r_state != RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_instr <= '0;
            r_id_pc    <= '0;
            r_ex_func  <= '0;
            r_ex_regwr <= 1'b0;
            r_ex_rw    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_ds) begin
                r_ex_func  <= '0;
                r_ex_regwr <= 1'b0;
                r_ex_rw    <= '0;
            end else begin
                if (w_bs) begin
                    r_id_instr <= NOP_INSTR;
                end else begin
                    r_id_instr <= IFinstr;
                    r_id_pc    <= IFpc;
                end
                r_ex_func  <= IDfunc;
                r_ex_regwr <= IDRegWr;
                r_ex_rw    <= IDrw;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign IDinstr   = r_id_instr;
    assign IDpc      = r_id_pc;
    assign EXfunc    = r_ex_func;
    assign EXRegWr   = r_ex_regwr;
    assign EXrw      = r_ex_rw;
    assign stall_err = r_err;

`ifdef PIPE_HOLD_PERF_EN
    sat_cnt #(.W(CNT_W)) u_data_stalls (
        .clk (clk),
        .clr (rst),
        .inc (w_ds),
        .q   (data_stalls)
    );

    sat_cnt #(.W(CNT_W)) u_branch_stalls (
        .clk (clk),
        .clr (rst),
        .inc (w_bs),
        .q   (branch_stalls)
    );
`else
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule

// File: doc/pipe_hold.md
# pipe_hold

Pipeline-register bank that consumes the hazard unit's `IFstall`/`IDstall` outputs and enforces them. It holds the PC and the IF/ID latch, injects NOP bubbles into IF/ID on branch stalls and into ID/EX on data stalls, and tracks stall episodes in a small FSM. It sits between the fetch stage, the decode stage and the hazard unit of the 5-stage MIPS pipeline, and owns the IF/ID and ID/EX control registers.

## Interface
Parameters:
- `MAX_STALL`, 4: consecutive stall cycles allowed before `stall_err` sets.
- `CNT_W`, 16: width of the performance counters (see Configuration).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `IFstall`  in  1  branch in ID/EX; fetch must not advance.
- `IDstall`  in  1  RAW hazard on Rs/Rt; decode must not advance.
- `IFinstr`  in  32  fetched instruction.
- `IFpc`  in  32  PC+4 of the fetched instruction.
- `IDfunc`  in  15  one-hot decoded function of the instruction in ID.
- `IDRegWr`  in  1  ID instruction writes the register file.
- `IDrw`  in  5  ID destination register.
- `PCwrite`  out  1  PC register enable (combinational).
- `IDinstr`  out  32  IF/ID instruction latch.
- `IDpc`  out  32  IF/ID PC latch.
- `EXfunc`  out  15  ID/EX function register.
- `EXRegWr`  out  1  ID/EX register-write enable.
- `EXrw`  out  5  ID/EX destination register.
- `stall_err`  out  1  sticky watchdog flag.
- `data_stalls`, `branch_stalls`  out  CNT_W each  only when `PIPE_HOLD_PERF_EN` is defined.

## Operation
- Priority: `IDstall` over `IFstall`. Qualified data stall `ds = IDstall`; qualified branch stall `bs = IFstall & ~IDstall`.
- `PCwrite = ~rst & ~IFstall & ~IDstall`.
- Data stall (`ds`):
  - IF/ID holds its value.
  - ID/EX loads a bubble: `EXfunc=0`, `EXRegWr=0`, `EXrw=0`.
- Branch stall (`bs`):
  - IF/ID loads NOP (`IDinstr=32'h0`); `IDpc` holds.
  - ID/EX loads the ID values normally.
- No stall: IF/ID loads `IFinstr`/`IFpc`; ID/EX loads `IDfunc`/`IDRegWr`/`IDrw`.
- FSM states RUN, DSTALL, BSTALL (registered). Next state is DSTALL if `ds`, else BSTALL if `bs`, else RUN. Direct DSTALL↔BSTALL transitions are legal.
- Stall-run counter `run_cnt` (width clog2(MAX_STALL+2)):
  - Increments every cycle in which `ds|bs` is true, saturating at MAX_STALL+1.
  - Clears on any cycle with no stall.
- `stall_err` sets on the edge where `run_cnt` would exceed MAX_STALL. It stays set until `rst`.

## Timing
- All registers update on the rising edge of `clk`. `PCwrite` is the only combinational output.
- Hazard response latency:
  - The bubble appears at `EXfunc` the cycle after `ds` is sampled.
  - The NOP appears at `IDinstr` the cycle after `bs` is sampled.
- Reset (synchronous, takes effect at the edge where `rst=1`):
  - All registered outputs clear to 0, the FSM goes to RUN, and `run_cnt` and the counters clear.
  - `PCwrite=0` while `rst` is high.
- Reset mid-stall: `rst` wins over every stall input; no held value survives.
- Simultaneous `IFstall`+`IDstall`: treated as a data stall only. IF/ID holds (no NOP) and ID/EX bubbles.
- MAX_STALL consecutive stall cycles do not set `stall_err`; the (MAX_STALL+1)th cycle sets it on that cycle's edge.

## Configuration
- `PIPE_HOLD_PERF_EN` defined:
  - `data_stalls` increments on every `ds` cycle; `branch_stalls` increments on every `bs` cycle.
  - Both saturate at all-ones and clear on `rst`.
- Not defined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - `NOP_INSTR` = 32'h0.
  - `FUNC_W` = 15 and `REG_W` = 5.
  - FSM state encoding: RUN=2'd0, DSTALL=2'd1, BSTALL=2'd2.
- One sub-module, `sat_cnt`: parameterised-width saturating counter with synchronous clear and increment enable. It is instantiated for `run_cnt` and for each performance counter.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `IFinstr=32'h8C220004` → all registered outputs 0, `PCwrite=0`, `stall_err=0`; next cycle without stall → `IDinstr=32'h8C220004`, `PCwrite=1`.
- Data stall: `IDstall=1` for 1 cycle with `IDfunc=15'h0400`, `IDRegWr=1`, `IDrw=5'd3` →
  - `PCwrite=0`, `IDinstr` held, then `EXfunc=0`, `EXRegWr=0`, `EXrw=0`.
  - The next free cycle passes `IDfunc=15'h0400` into EX.
- Branch stall: `IFstall=1` for 2 cycles with `IDfunc=15'h0010` (beq) → `IDinstr=32'h0` both cycles and `EXfunc=15'h0010` after the first edge; `PCwrite=0` for both cycles.
- Both stalls together: `IFstall=IDstall=1` → `IDinstr` held (not NOP), EX bubbled, FSM=DSTALL; with `PIPE_HOLD_PERF_EN`, `data_stalls` increments by 1 and `branch_stalls` does not.
- Watchdog: MAX_STALL=4, assert `IDstall` for 4 cycles → `stall_err=0`; a 5th cycle → `stall_err=1`, which stays 1 after the stall drops and until `rst`.
- Counter saturation (CNT_W=4, PERF_EN): 20 branch-stall cycles with MAX_STALL=31 → `branch_stalls=4'hF`; `rst` → 0.
